idct_row_engine: RTL and testbench
==================================

# idct_row_engine

8-point one-dimensional inverse DCT engine: the decode-side counterpart of the row-serial forward DCT array. It accepts one block of eight frequency coefficients X[0..7] serially, in natural order, and returns eight spatial samples x[0..7] serially. Two instances with a transpose buffer between them form the 2-D IDCT used for reconstruction and self-check of the forward path.

## Interface
- DATA_WIDTH, 12, signed width of input coefficients and output samples.
- COE_WIDTH, 10, signed width of the internal cosine weights, Q1.(COE_WIDTH-1) format.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  DATA_WIDTH  coefficient X[k], signed.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  engine accepts in_data this cycle.
- out_data  out  DATA_WIDTH  sample x[n], signed.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data this cycle.

## Operation
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Function: x[n] = Σk W[n][k]·X[k].
  - W[n][k] = round(0.5·C(k)·cos((2n+1)kπ/16)·2^(COE_WIDTH-1)).
  - C(0) = 1/√2; C(k>0) = 1.
  - W is held in a constant 8x8 table computed at elaboration.
- Input side:
  - 3-bit counter in_cnt gives k.
  - On each input transfer, all eight accumulators update in parallel: acc[n] = (in_cnt==0 ? 0 : acc[n]) + W[n][in_cnt]·X. Eight multipliers are used.
  - in_cnt wraps 7→0.
- Accumulator width: DATA_WIDTH+COE_WIDTH+3, signed. Products are sign-extended and accumulation never overflows.
- Result formation: r = (acc + 2^(COE_WIDTH-2)) >>> (COE_WIDTH-1), then saturated to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Output buffer: eight registers, with a two-state FSM.
  - EMPTY to DRAIN: on the transfer of X[7]. The eight rounded and saturated results are loaded and out_cnt is set to 0.
  - DRAIN: out_valid=1, out_data = buf[out_cnt]. Each output transfer increments out_cnt.
  - DRAIN to EMPTY: on the transfer of x[7], unless a new block completes in the same cycle. In that case the buffer reloads and the FSM stays in DRAIN.
- Accumulators and the output buffer are separate. Block N+1 accumulates while block N drains.
- Backpressure:
  - in_ready = !(in_cnt==7 && state==DRAIN && !(out_cnt==7 && out_ready)).
  - Only the 8th coefficient of a block can stall. in_ready depends combinationally on out_ready.
- Reset (rst_n low at a clock edge), including mid-block or mid-drain:
  - in_cnt=0, out_cnt=0, state=EMPTY, all accumulators and buffers cleared.
  - A partial block is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0.
- Latency: X[7] transferred at edge t gives out_valid=1 with x[0] after edge t; x[n] is presented after edge t+n when out_ready stays high.
- Throughput: one block per 8 cycles with no bubbles when in_valid and out_ready are held high. out_valid stays high continuously across block boundaries.
- Held values:
  - out_data and out_valid hold while out_valid & !out_ready.
  - out_data is 0 in EMPTY.
- in_valid may drop at any coefficient; accumulation pauses with no state loss.

## Test plan
- Reset and idle: after reset, hold in_valid=0 for 20 cycles -> in_ready=1, out_valid=0, out_data=0 throughout.
- DC block, defaults: X = {64,0,0,0,0,0,0,0}, out_ready=1 -> W[n][0]=181; outputs x[0..7] all 23, starting the cycle after X[7]. Zero block -> eight 0s.
- Saturation: X[k]=2047 for all k -> x[0]=2047 (clipped). Negate every X -> x[0]=-2048. The remaining x[n] match a reference model bit-exactly.
- Streaming: 16 random blocks back-to-back, in_valid=out_ready=1 -> 128 outputs bit-exact vs. a fixed-point model; out_valid is never deasserted after the first output.
- Backpressure: out_ready=0 and feed two blocks -> in_ready drops exactly at the second block's X[7]. Raise out_ready for 7 cycles -> in_ready is still 0. On the 8th cycle, in_ready=1 in the same cycle x[7] transfers; block 2 loads with no gap, and random in_valid/out_ready toggling loses no data.
- Reset mid-operation: assert rst_n=0 after X[3] of block A, then send a DC block -> outputs all 23, none of block A's data appears.

Source files
------------

// File: rtl/idct_row_engine.sv
// 8-point 1-D inverse DCT, coefficients in serially, samples out serially.
// Eight parallel MAC lanes feed a separate output buffer so blocks overlap.
module idct_row_engine #(
  parameter int DATA_WIDTH = 12,
  parameter int COE_WIDTH  = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int ACC_W  = DATA_WIDTH + COE_WIDTH + 3;
  localparam int PROD_W = DATA_WIDTH + COE_WIDTH;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // cos(m*pi/16) in Q16 for m = 0..8
  function automatic int unsigned cos_q16(input int unsigned m);
    int unsigned c;
    case (m)
      0:       c = 65536;
      1:       c = 64277;
      2:       c = 60547;
      3:       c = 54491;
      4:       c = 46341;
      5:       c = 36410;
      6:       c = 25080;
      7:       c = 12785;
      default: c = 0;
    endcase
    return c;
  endfunction

  // Angle folded into the first quadrant; the k=0 weight 0.5/sqrt(2) equals 0.5*cos(pi/4).
  function automatic logic [64*COE_WIDTH-1:0] gen_coef();
    logic [64*COE_WIDTH-1:0]      t;
    logic signed [COE_WIDTH-1:0]  w;
    int unsigned                  m;
    int unsigned                  mag;
    logic                         neg;
    t = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      for (int unsigned k = 0; k < 8; k++) begin
        neg = 1'b0;
        if (k == 0) begin
          m = 4;
        end else begin
          m = ((2 * n + 1) * k) % 32;
          if (m > 16) m = 32 - m;
          if (m > 8) begin
            m   = 16 - m;
            neg = 1'b1;
          end
        end
        mag = (cos_q16(m) + (32'd1 << (17 - COE_WIDTH))) >> (18 - COE_WIDTH);
        w   = COE_WIDTH'(mag);
        if (neg) w = -w;
        t[(n * 8 + k) * COE_WIDTH +: COE_WIDTH] = w;
      end
    end
    return t;
  endfunction

  localparam logic [64*COE_WIDTH-1:0] COEF = gen_coef();

  typedef enum logic {EMPTY, DRAIN} state_t;

  state_t                        r_state;
  logic [2:0]                    r_in_cnt;
  logic [2:0]                    r_out_cnt;
  logic signed [ACC_W-1:0]       r_acc      [8];
  logic signed [DATA_WIDTH-1:0]  r_buf      [8];
  logic signed [DATA_WIDTH-1:0]  r_out_data;
  logic                          r_out_valid;

  logic signed [COE_WIDTH-1:0]   w_coef     [8];
  logic signed [PROD_W-1:0]      w_prod     [8];
  logic signed [ACC_W-1:0]       w_acc_next [8];
  logic signed [ACC_W-1:0]       w_rnd      [8];
  logic signed [DATA_WIDTH-1:0]  w_res      [8];
  logic                          w_in_fire;
  logic                          w_out_fire;
  logic                          w_load;

  assign in_ready   = !(r_in_cnt == 3'd7 && r_state == DRAIN && !(r_out_cnt == 3'd7 && out_ready));
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_load     = w_in_fire && (r_in_cnt == 3'd7);
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;

  always_comb begin
    for (int unsigned n = 0; n < 8; n++) begin
      w_coef[n]     = COEF[(n * 8 + 32'(r_in_cnt)) * COE_WIDTH +: COE_WIDTH];
      w_prod[n]     = PROD_W'(in_data) * PROD_W'(w_coef[n]);
      w_acc_next[n] = ((r_in_cnt == 3'd0) ? '0 : r_acc[n]) + ACC_W'(w_prod[n]);
      w_rnd[n]      = (w_acc_next[n] + ACC_W'(1 << (COE_WIDTH - 2))) >>> (COE_WIDTH - 1);
      if (w_rnd[n] > SAT_MAX)      w_res[n] = DATA_WIDTH'(SAT_MAX);
      else if (w_rnd[n] < SAT_MIN) w_res[n] = DATA_WIDTH'(SAT_MIN);
      else                         w_res[n] = DATA_WIDTH'(w_rnd[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_cnt <= '0;
      for (int unsigned n = 0; n < 8; n++) r_acc[n] <= '0;
    end else if (w_in_fire) begin
      r_in_cnt <= r_in_cnt + 3'd1;
      for (int unsigned n = 0; n < 8; n++) r_acc[n] <= w_acc_next[n];
    end
  end

  // A completing block may only load alongside the final drain transfer, so load wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_out_cnt   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      for (int unsigned n = 0; n < 8; n++) r_buf[n] <= '0;
    end else if (w_load) begin
      r_state     <= DRAIN;
      r_out_cnt   <= '0;
      r_buf       <= w_res;
      r_out_data  <= w_res[0];
      r_out_valid <= 1'b1;
    end else if (w_out_fire) begin
      if (r_out_cnt == 3'd7) begin
        r_state     <= EMPTY;
        r_out_cnt   <= '0;
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
      end else begin
        r_out_cnt  <= r_out_cnt + 3'd1;
        r_out_data <= r_buf[r_out_cnt + 3'd1];
      end
    end
  end

endmodule

// File: tb/tb_idct_row_engine.sv
// Bench for idct_row_engine: random blocks against a floating-point-derived
// weight table and plain integer arithmetic.
module tb_idct_row_engine;
  localparam int  DW = 12;
  localparam int  CW = 10;
  localparam real PI = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  int n_checks = 0;
  int n_errors = 0;
  int stim[$];
  int q_exp[$];
  int q_out[$];
  logic s_in_ready, s_out_valid;
  logic signed [DW-1:0] s_out_data;

  always #5 clk = ~clk;

  idct_row_engine #(.DATA_WIDTH(DW), .COE_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int w_ref(input int n, input int k);
    real c, v;
    c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v = 0.5 * c * $cos(real'((2 * n + 1) * k) * PI / 16.0) * (2.0 ** (CW - 1));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  // kind: 0 random, 1 DC 64, 2 zero, 3 all +2047, 4 all -2047
  task automatic gen_block(input int kind);
    int b[8];
    longint acc, r;
    for (int k = 0; k < 8; k++) begin
      case (kind)
        0:       b[k] = int'($urandom_range(4095)) - 2048;
        1:       b[k] = (k == 0) ? 64 : 0;
        3:       b[k] = 2047;
        4:       b[k] = -2047;
        default: b[k] = 0;
      endcase
      stim.push_back(b[k]);
    end
    for (int n = 0; n < 8; n++) begin
      acc = 0;
      for (int k = 0; k < 8; k++) acc += longint'(w_ref(n, k)) * longint'(b[k]);
      r = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
      if (r > (longint'(1) << (DW - 1)) - 1) r = (longint'(1) << (DW - 1)) - 1;
      if (r < -(longint'(1) << (DW - 1)))    r = -(longint'(1) << (DW - 1));
      q_exp.push_back(int'(r));
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    if (in_valid && in_ready && stim.size() > 0) void'(stim.pop_front());
    if (out_valid && out_ready) q_out.push_back(int'(out_data));
    @(posedge clk);
    #1;
  endtask

  task automatic run_stim(input int n_exp, input int pv, input int pr, input int budget,
                          output int cycles, output int gaps);
    cycles = 0;
    gaps   = 0;
    while ((stim.size() > 0 || q_out.size() < n_exp) && cycles < budget) begin
      in_valid  = (stim.size() > 0) && ($urandom_range(99) < pv);
      in_data   = (stim.size() > 0) ? DW'(stim[0]) : '0;
      out_ready = ($urandom_range(99) < pr);
      step();
      if (q_out.size() > 0 && !s_out_valid && q_out.size() < n_exp) gaps++;
      cycles++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (cycles >= budget) begin
      n_errors++;
      $display("FAIL timeout: got %0d outputs after %0d cycles, expected %0d", q_out.size(), cycles, n_exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stim.delete(); q_exp.delete(); q_out.delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
        n_errors++;
        $display("FAIL reset_idle cyc %0d: in_ready=%b out_valid=%b out_data=%0d, expected 1 0 0",
                 i, in_ready, out_valid, out_data);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_dc();
    int cyc, gaps;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = (k == 0) ? DW'(64) : '0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(23)) begin
        n_errors++;
        $display("FAIL dc_latency x[%0d]: valid=%b data=%0d, expected 1 23", n, out_valid, out_data);
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_errors++;
      $display("FAIL dc_empty: valid=%b data=%0d, expected 0 0", out_valid, out_data);
    end
    stim.delete(); q_exp.delete(); q_out.delete();
    gen_block(2);
    run_stim(8, 100, 100, 200, cyc, gaps);
    n_checks++;
    if (q_out.size() !== 8) begin
      n_errors++;
      $display("FAIL zero_count: got %0d expected 8", q_out.size());
    end
    for (int i = 0; i < q_out.size() && i < q_exp.size(); i++) begin
      n_checks++;
      if (q_out[i] !== q_exp[i]) begin
        n_errors++;
        $display("FAIL zero x[%0d]: got %0d expected %0d", i, q_out[i], q_exp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int cyc, gaps;
    stim.delete(); q_exp.delete(); q_out.delete();
    gen_block(3);
    gen_block(4);
    run_stim(16, 100, 100, 400, cyc, gaps);
    if (q_out.size() >= 16) begin
      n_checks++;
      if (q_out[0] !== 2047 || q_out[8] !== -2048) begin
        n_errors++;
        $display("FAIL sat_clip: got %0d / %0d expected 2047 / -2048", q_out[0], q_out[8]);
      end
    end
    for (int i = 0; i < q_out.size() && i < q_exp.size(); i++) begin
      n_checks++;
      if (q_out[i] !== q_exp[i]) begin
        n_errors++;
        $display("FAIL sat x[%0d]: got %0d expected %0d", i, q_out[i], q_exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, gaps;
    stim.delete(); q_exp.delete(); q_out.delete();
    for (int b = 0; b < 16; b++) gen_block(0);
    run_stim(128, 100, 100, 1000, cyc, gaps);
    n_checks++;
    if (cyc !== 136 || gaps !== 0) begin
      n_errors++;
      $display("FAIL stream_rate: cycles=%0d gaps=%0d expected 136 0", cyc, gaps);
    end
    for (int i = 0; i < q_out.size() && i < q_exp.size(); i++) begin
      n_checks++;
      if (q_out[i] !== q_exp[i]) begin
        n_errors++;
        $display("FAIL stream x[%0d]: got %0d expected %0d", i, q_out[i], q_exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc, gaps;
    stim.delete(); q_exp.delete(); q_out.delete();
    gen_block(0);
    gen_block(0);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(stim[0]);
      step();
      n_checks++;
      if (s_in_ready !== (i != 15)) begin
        n_errors++;
        $display("FAIL bp_stall coef %0d: in_ready=%b expected %b", i, s_in_ready, (i != 15));
      end
    end
    n_checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== DW'(q_exp[0])) begin
      n_errors++;
      $display("FAIL bp_hold: valid=%b data=%0d expected 1 %0d", s_out_valid, s_out_data, q_exp[0]);
    end
    for (int j = 0; j < 8; j++) begin
      out_ready = 1'b1;
      in_data   = (stim.size() > 0) ? DW'(stim[0]) : '0;
      step();
      n_checks++;
      if (s_in_ready !== (j == 7)) begin
        n_errors++;
        $display("FAIL bp_release cyc %0d: in_ready=%b expected %b", j, s_in_ready, (j == 7));
      end
    end
    n_checks++;
    if (stim.size() !== 0 || q_out.size() !== 8) begin
      n_errors++;
      $display("FAIL bp_swap: pending=%0d outputs=%0d expected 0 8", stim.size(), q_out.size());
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (s_out_valid !== 1'b1 || q_out.size() !== 9) begin
      n_errors++;
      $display("FAIL bp_nogap: valid=%b outputs=%0d expected 1 9", s_out_valid, q_out.size());
    end
    gen_block(0);
    gen_block(0);
    run_stim(32, 60, 50, 3000, cyc, gaps);
    for (int i = 0; i < q_out.size() && i < q_exp.size(); i++) begin
      n_checks++;
      if (q_out[i] !== q_exp[i]) begin
        n_errors++;
        $display("FAIL bp x[%0d]: got %0d expected %0d", i, q_out[i], q_exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, gaps;
    stim.delete(); q_exp.delete(); q_out.delete();
    gen_block(0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(stim[0]);
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    stim.delete(); q_exp.delete(); q_out.delete();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_state: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    gen_block(1);
    run_stim(8, 100, 100, 200, cyc, gaps);
    repeat (10) step();
    n_checks++;
    if (q_out.size() !== 8) begin
      n_errors++;
      $display("FAIL midreset_count: got %0d outputs expected 8", q_out.size());
    end
    for (int i = 0; i < q_out.size() && i < 8; i++) begin
      n_checks++;
      if (q_out[i] !== 23) begin
        n_errors++;
        $display("FAIL midreset x[%0d]: got %0d expected 23", i, q_out[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
